// File: rtl/baud_rate_controller.sv
// Divisor shadow/commit sequencer for the UART baud generator, plus the
// oversample divider that turns generator overflow ticks into per-bit ticks.
module baud_rate_controller #(
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd325,
  parameter int unsigned OVERSAMPLE      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [1:0]  wr_addr_i,
  input  logic [7:0]  wr_data_i,
  input  logic [1:0]  rd_addr_i,
  output logic [7:0]  rd_data_o,
  input  logic        tx_busy_i,
  input  logic        rx_busy_i,
  input  logic        baud_tick_i,
  output logic [15:0] divisor_o,
  output logic        gen_rst_n_o,
  output logic        bit_tick_o,
  output logic        cfg_pending_o
);

  localparam int unsigned CntW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {StIdle, StPending, StApply} state_e;

  state_e          state_q, state_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [15:0]     staged_q;
  logic [15:0]     divisor_q;
  logic            enable_q, enable_d;
  logic            err_q, err_d;
  logic            err_set;
  logic            pending_q;
  logic            gen_rst_n_q;
  logic            bit_tick_q;
  logic [CntW-1:0] cnt_q;

  logic ctrl_wr;
  logic commit_req;
  logic shadow_zero;
  logic apply;
  logic busy_free;
  logic count_en;
  logic wrap;
  logic capture;

  // Register write decode
  always_comb begin
    ctrl_wr     = wr_en_i && (wr_addr_i == 2'd2);
    // Rising enable acts as an implicit commit.
    commit_req  = ctrl_wr && (wr_data_i[0] || (wr_data_i[1] && !enable_q));
    enable_d    = ctrl_wr ? wr_data_i[1] : enable_q;
    shadow_zero = (shadow_q == 16'd0);
    busy_free   = !tx_busy_i && !rx_busy_i;

    shadow_d = shadow_q;
    if (wr_en_i && (wr_addr_i == 2'd0)) begin
      shadow_d[7:0] = wr_data_i;
    end
    if (wr_en_i && (wr_addr_i == 2'd1)) begin
      shadow_d[15:8] = wr_data_i;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (commit_req) begin
          if (shadow_zero) begin
            err_set = 1'b1;
          end else begin
            state_d = StPending;
          end
        end
      end
      StPending: begin
        if (busy_free) begin
          state_d = StApply;
        end
      end
      StApply: begin
        state_d = StIdle;
        if (commit_req) begin
          if (shadow_zero) begin
            err_set = 1'b1;
          end else begin
            state_d = StPending;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Disabling cancels any commit in flight.
    if (!enable_d) begin
      state_d = StIdle;
    end
  end

  // FSM: outputs
  always_comb begin
    apply    = (state_q == StApply);
    capture  = (state_q == StPending) && (state_d == StApply);
    count_en = enable_q && !apply;
    wrap     = count_en && baud_tick_i && (cnt_q == CntMax);

    err_d = err_q;
    if (ctrl_wr && wr_data_i[2]) begin
      err_d = 1'b0;
    end
    if (err_set) begin
      err_d = 1'b1;
    end

    rd_data_o = 8'h00;
    unique case (rd_addr_i)
      2'd0:    rd_data_o = shadow_q[7:0];
      2'd1:    rd_data_o = shadow_q[15:8];
      2'd2:    rd_data_o = {5'b0, err_q, pending_q, enable_q};
      2'd3:    rd_data_o = divisor_q[7:0];
      default: rd_data_o = 8'h00;
    endcase

    divisor_o     = divisor_q;
    gen_rst_n_o   = gen_rst_n_q;
    bit_tick_o    = bit_tick_q;
    cfg_pending_o = pending_q;
  end

  // Configuration and status registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q  <= DEFAULT_DIVISOR;
      staged_q  <= DEFAULT_DIVISOR;
      divisor_q <= DEFAULT_DIVISOR;
      enable_q  <= 1'b1;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      enable_q  <= enable_d;
      err_q     <= err_d;
      pending_q <= (state_q != StIdle);
      // The divisor taken is the shadow seen when busy finally drops.
      if (capture) begin
        staged_q <= shadow_q;
      end
      if (apply) begin
        divisor_q <= staged_q;
      end
    end
  end

  // Generator restart and oversample divider
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gen_rst_n_q <= 1'b0;
      bit_tick_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      gen_rst_n_q <= enable_q && !apply;
      bit_tick_q  <= wrap;
      if (!count_en) begin
        cnt_q <= '0;
      end else if (baud_tick_i) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_baud_rate_controller.sv
// Self-checking bench for baud_rate_controller: directed scenarios with
// randomized divisors, busy lengths and tick spacing against a timing model.
module tb_baud_rate_controller;

  localparam int unsigned OS = 16;
  localparam logic [15:0] DEF = 16'd325;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        tx_busy;
  logic        rx_busy;
  logic        baud_tick;
  logic [15:0] divisor;
  logic        gen_rst_n;
  logic        bit_tick;
  logic        cfg_pending;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_div;

  always #5 clk = ~clk;

  baud_rate_controller #(
    .DEFAULT_DIVISOR(DEF),
    .OVERSAMPLE     (OS)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .tx_busy_i    (tx_busy),
    .rx_busy_i    (rx_busy),
    .baud_tick_i  (baud_tick),
    .divisor_o    (divisor),
    .gen_rst_n_o  (gen_rst_n),
    .bit_tick_o   (bit_tick),
    .cfg_pending_o(cfg_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(tag, {24'h0, rd_data}, {24'h0, exp});
  endtask

  // Commit val; hold one busy line for busy_cycles edges, rewriting DLL midway.
  task automatic do_commit(input logic [15:0] val, input int busy_cycles, input bit use_rx,
                           input logic [7:0] rewrite);
    logic [15:0] nv;
    nv = val;
    wr(2'd0, val[7:0]);
    wr(2'd1, val[15:8]);
    if (busy_cycles > 0) begin
      if (use_rx) rx_busy = 1'b1;
      else tx_busy = 1'b1;
    end
    wr(2'd2, 8'h03);
    check("pend_lag", {31'h0, cfg_pending}, 32'h0);
    for (int i = 0; i < busy_cycles; i++) begin
      if (busy_cycles >= 2 && i == busy_cycles / 2) begin
        nv[7:0] = rewrite;
        wr(2'd0, rewrite);
      end else begin
        step();
      end
      check("div_hold", {16'h0, divisor}, {16'h0, exp_div});
      check("pend_wait", {31'h0, cfg_pending}, 32'h1);
    end
    tx_busy = 1'b0;
    rx_busy = 1'b0;
    step();
    check("div_pre", {16'h0, divisor}, {16'h0, exp_div});
    check("pend_pre", {31'h0, cfg_pending}, 32'h1);
    check("grst_pre", {31'h0, gen_rst_n}, 32'h1);
    step();
    exp_div = nv;
    check("div_new", {16'h0, divisor}, {16'h0, exp_div});
    check("grst_low", {31'h0, gen_rst_n}, 32'h0);
    check("pend_apply", {31'h0, cfg_pending}, 32'h1);
    step();
    check("grst_back", {31'h0, gen_rst_n}, 32'h1);
    check("pend_done", {31'h0, cfg_pending}, 32'h0);
    rd_check("rd_div_lo", 2'd3, nv[7:0]);
  endtask

  // One tick after a random gap; the model counts accepted ticks.
  task automatic tick_once(inout int accepted, inout int pulses);
    int gap;
    gap = $urandom_range(0, 3);
    for (int g = 0; g < gap; g++) begin
      step();
      check("bt_idle", {31'h0, bit_tick}, 32'h0);
    end
    baud_tick = 1'b1;
    step();
    baud_tick = 1'b0;
    accepted++;
    check("bt", {31'h0, bit_tick}, ((accepted % OS) == 0) ? 32'h1 : 32'h0);
    if (bit_tick) pulses++;
  endtask

  initial begin
    int accepted;
    int pulses;
    logic [15:0] v;

    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = 2'd0;
    wr_data   = 8'h00;
    rd_addr   = 2'd0;
    tx_busy   = 1'b0;
    rx_busy   = 1'b0;
    baud_tick = 1'b0;
    exp_div   = DEF;

    // Reset defaults
    repeat (3) step();
    check("rst_div", {16'h0, divisor}, {16'h0, DEF});
    check("rst_grst", {31'h0, gen_rst_n}, 32'h0);
    check("rst_bt", {31'h0, bit_tick}, 32'h0);
    check("rst_pend", {31'h0, cfg_pending}, 32'h0);
    rd_check("rst_ctrl", 2'd2, 8'h01);
    rst = 1'b0;
    step();
    check("rel_grst", {31'h0, gen_rst_n}, 32'h1);
    rd_check("rst_sh_lo", 2'd0, DEF[7:0]);
    rd_check("rst_sh_hi", 2'd1, DEF[15:8]);

    // Idle commit
    do_commit(16'h001A, 0, 1'b0, 8'h00);

    // Busy deferral with DLL rewrite while pending
    tx_busy = 1'b1;
    repeat (50) step();
    do_commit(16'h0100, 10, 1'b0, 8'h20);
    check("defer_val", {16'h0, divisor}, 32'h0120);

    // Zero divisor: sticky error, set wins over clear
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h03);
    step();
    check("zero_pend", {31'h0, cfg_pending}, 32'h0);
    rd_check("zero_err", 2'd2, 8'h05);
    step();
    check("zero_div", {16'h0, divisor}, {16'h0, exp_div});
    wr(2'd2, 8'h07);
    rd_check("err_setwins", 2'd2, 8'h05);
    wr(2'd2, 8'h06);
    rd_check("err_clear", 2'd2, 8'h01);
    check("zero_div2", {16'h0, divisor}, {16'h0, exp_div});

    // Randomized commits
    for (int k = 0; k < 8; k++) begin
      v = 16'($urandom_range(1, 65535));
      do_commit(v, $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                8'($urandom_range(1, 255)));
    end

    // Bit tick: 40 ticks give pulses after the 16th and 32nd
    accepted = 0;
    pulses   = 0;
    for (int t = 0; t < 40; t++) tick_once(accepted, pulses);
    step();
    check("bt_after", {31'h0, bit_tick}, 32'h0);
    check("bt_total", pulses, 2);

    // Disable mid-count, ticks ignored, then re-enable (implicit commit)
    for (int t = 0; t < 5; t++) tick_once(accepted, pulses);
    wr(2'd2, 8'h00);
    step();
    check("dis_grst", {31'h0, gen_rst_n}, 32'h0);
    rd_check("dis_ctrl", 2'd2, 8'h00);
    for (int t = 0; t < 20; t++) begin
      baud_tick = 1'b1;
      step();
      baud_tick = 1'b0;
      check("dis_bt", {31'h0, bit_tick}, 32'h0);
      check("dis_grst_hold", {31'h0, gen_rst_n}, 32'h0);
    end
    wr(2'd2, 8'h02);
    step();
    step();
    check("en_grst_low", {31'h0, gen_rst_n}, 32'h0);
    check("en_div", {16'h0, divisor}, {16'h0, exp_div});
    step();
    check("en_grst_back", {31'h0, gen_rst_n}, 32'h1);
    accepted = 0;
    pulses   = 0;
    for (int t = 0; t < 20; t++) tick_once(accepted, pulses);
    check("en_bt_total", pulses, 1);

    // Reset while pending with tx busy
    v = 16'($urandom_range(1, 65535));
    wr(2'd0, v[7:0]);
    wr(2'd1, v[15:8]);
    tx_busy = 1'b1;
    wr(2'd2, 8'h03);
    step();
    check("pre_rst_pend", {31'h0, cfg_pending}, 32'h1);
    rst = 1'b1;
    step();
    step();
    check("mid_rst_pend", {31'h0, cfg_pending}, 32'h0);
    check("mid_rst_grst", {31'h0, gen_rst_n}, 32'h0);
    rst = 1'b0;
    step();
    exp_div = DEF;
    check("post_rst_grst", {31'h0, gen_rst_n}, 32'h1);
    check("post_rst_div", {16'h0, divisor}, {16'h0, DEF});
    rd_check("post_rst_lo", 2'd0, DEF[7:0]);
    rd_check("post_rst_hi", 2'd1, DEF[15:8]);
    rd_check("post_rst_ctrl", 2'd2, 8'h01);
    tx_busy = 1'b0;
    for (int t = 0; t < 5; t++) begin
      step();
      check("noapply_div", {16'h0, divisor}, {16'h0, DEF});
      check("noapply_grst", {31'h0, gen_rst_n}, 32'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/baud_rate_controller.md
# baud_rate_controller

Configuration and sequencing controller for the UART baud rate generator. It holds a byte-writable shadow copy of the 16-bit divisor and commits it to the generator atomically, only when both TX and RX are idle. On commit it restarts the generator cleanly. It also divides the generator's overflow tick by the oversampling factor to produce the per-bit tick used by the transmitter.

## Interface

Parameters:
- DEFAULT_DIVISOR, 16'd325: divisor loaded into the shadow and active registers at reset.
- OVERSAMPLE, 16: baud ticks per bit tick; must be a power of 2, ≥ 2.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- wr_en_i  in  1  register write strobe.
- wr_addr_i  in  2  register address: 0 = DLL, 1 = DLM, 2 = CTRL.
- wr_data_i  in  8  write data.
- rd_addr_i  in  2  read address.
- rd_data_o  out  8  combinational read data:
  - 0 = shadow low byte
  - 1 = shadow high byte
  - 2 = {5'b0, err, pending, enable}
  - 3 = active divisor low byte
- tx_busy_i  in  1  transmitter mid-frame.
- rx_busy_i  in  1  receiver mid-frame.
- baud_tick_i  in  1  overflow tick from the generator.
- divisor_o  out  16  active divisor driven to the generator.
- gen_rst_n_o  out  1  active-low synchronous reset to the generator.
- bit_tick_o  out  1  one-cycle pulse every OVERSAMPLE accepted baud ticks.
- cfg_pending_o  out  1  commit requested, not yet applied.

## Operation

**Registers**
- shadow[15:0]: DLL/DLM writes update the corresponding byte immediately, in any state.
- CTRL write bits:
  - bit0 = commit
  - bit1 = enable (stored)
  - bit2 = clear err

**FSM states:** IDLE, PENDING, APPLY.
- IDLE:
  - CTRL write with commit = 1 and shadow ≠ 0 → PENDING.
  - CTRL write with commit = 1 and shadow == 0 → err set (sticky); state stays IDLE.
  - CTRL write with enable 0→1 → PENDING, as an implicit commit (the zero-shadow check also applies).
- PENDING:
  - Both tx_busy_i and rx_busy_i low → APPLY.
  - Otherwise wait indefinitely.
  - A further commit has no effect.
  - DLL/DLM writes still land; the value used is the shadow at the PENDING→APPLY edge.
- APPLY (exactly 1 cycle):
  - divisor_o ← shadow.
  - gen_rst_n_o = 0.
  - Oversample counter cleared.
  - Next state IDLE.
  - A commit arriving in this cycle → PENDING instead of IDLE.

**Enable**
- enable = 0: gen_rst_n_o held 0, bit_tick_o held 0, oversample counter held at 0. Any pending commit is cancelled (→ IDLE).

**Oversample counter**
- Width log2(OVERSAMPLE); increments on baud_tick_i when enable = 1 and state ≠ APPLY.
- bit_tick_o = 1 on the cycle after the counter wraps OVERSAMPLE−1 → 0 (registered).

**Error flag**
- err cleared by a CTRL write with bit2 = 1.
- If a write sets bit2 and triggers a new error in the same cycle, the set wins.

**Reset**
- Applies in any state, including mid-PENDING or mid-APPLY.
- Returns every register to its reset value; an in-flight commit is discarded.

## Timing

**Reset values**
- divisor_o = DEFAULT_DIVISOR
- shadow = DEFAULT_DIVISOR
- gen_rst_n_o = 0
- bit_tick_o = 0
- cfg_pending_o = 0
- err = 0
- enable = 1
- state = IDLE
- First cycle after rst_i falls: gen_rst_n_o = 1.

**Commit latency**
- Commit write sampled at edge N → cfg_pending_o = 1 from N+1.
- If not busy at N+1: APPLY during N+1→N+2, divisor_o updated at edge N+2, gen_rst_n_o = 0 for cycle N+2.
- gen_rst_n_o = 1 and cfg_pending_o = 0 from N+3.

**General rules**
- busy inputs are sampled only in PENDING. A busy rising during APPLY is not a hazard, because the frame starts after the restart.
- divisor_o never changes outside APPLY.
- bit_tick_o is never asserted in the same cycle as gen_rst_n_o = 0.

## Test plan

1. **Reset defaults.** Release reset.
   - Required: divisor_o = 325, gen_rst_n_o = 0 then 1.
   - Reading addr 2 returns 8'h01.
2. **Idle commit.** Write DLL = 8'h1A, DLM = 8'h00, CTRL = 8'h03 with busy inputs low.
   - Required: divisor_o = 16'h001A exactly 2 cycles after the CTRL write.
   - gen_rst_n_o low for exactly 1 cycle; cfg_pending_o high for exactly 2 cycles.
3. **Busy deferral.** Hold tx_busy_i = 1 for 50 cycles, then commit 16'h0100; rewrite DLL = 8'h20 while pending.
   - Required: divisor_o unchanged until 2 cycles after tx_busy_i falls, then becomes 16'h0120.
4. **Zero divisor.** Set shadow = 0 and commit.
   - Required: err = 1, no pending, divisor_o unchanged.
   - CTRL = 8'h06 clears err.
5. **Bit tick.** Drive 40 baud_tick_i pulses with OVERSAMPLE = 16.
   - Required: exactly 2 bit_tick_o pulses, each 1 cycle after the 16th and 32nd ticks.
   - Disabling mid-count holds the counter at 0.
6. **Reset mid-PENDING.** Assert rst_i while PENDING with tx_busy_i = 1.
   - Required: cfg_pending_o = 0, shadow = divisor_o = 325 afterward, and no APPLY occurs.
